// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B computed LSB first as A + ~B + 1
// through one full-adder cell, with Y86 condition codes and unsigned borrow-out.
module serial_subtractor #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             ZF,
   output logic             SF,
   output logic             OF
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_sa, r_sb;
   logic [WIDTH-2:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_a_msb, r_b_msb;
   logic             w_sum, w_cout, w_last;
   logic [WIDTH-1:0] w_res;

   assign w_sum  = r_sa[0] ^ r_sb[0] ^ r_carry;
   assign w_cout = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
   // Sum bits enter from the MSB side so the result is aligned after WIDTH shifts.
   assign w_res  = {w_sum, r_res};
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Diff    <= '0;
         Bout    <= 1'b0;
         ZF      <= 1'b0;
         SF      <= 1'b0;
         OF      <= 1'b0;
      end else begin
         busy <= (w_next == RUN);
         done <= (w_next == DONE);
         case (r_state)
            IDLE: if (start) begin
               r_sa    <= A;
               r_sb    <= ~B;
               r_carry <= 1'b1;
               r_cnt   <= '0;
               // Operand signs are kept here since the shift registers lose them.
               r_a_msb <= A[WIDTH-1];
               r_b_msb <= B[WIDTH-1];
            end
            RUN: begin
               r_sa    <= r_sa >> 1;
               r_sb    <= r_sb >> 1;
               r_res   <= w_res[WIDTH-1:1];
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  Diff <= w_res;
                  Bout <= ~w_cout;
                  ZF   <= (w_res == '0);
                  SF   <= w_sum;
                  OF   <= (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=64 and WIDTH=4,
// checked against a plain-arithmetic reference model.
module tb_serial_subtractor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        st64, st4;
   logic [63:0] a64, b64, diff64;
   logic        busy64, done64, bout64, zf64, sf64, of64;
   logic [3:0]  a4, b4, diff4;
   logic        busy4, done4, bout4, zf4, sf4, of4;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .start(st64), .A(a64), .B(b64),
      .busy(busy64), .done(done64), .Diff(diff64), .Bout(bout64),
      .ZF(zf64), .SF(sf64), .OF(of64));

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4),
      .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4),
      .ZF(zf4), .SF(sf4), .OF(of4));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (rst_n) begin
      checks++;
      assert (!((busy64 && done64) || (busy4 && done4))) else begin
         failures++;
         $error("FAIL busy_done_overlap got=1 exp=0");
      end
   end

   task automatic model64(input logic [63:0] a, input logic [63:0] b, output logic [63:0] d,
                          output logic bo, output logic zf, output logic sf, output logic of);
      logic signed [64:0] sd;
      d  = a - b;
      bo = (a < b);
      zf = (d == 64'd0);
      sf = d[63];
      sd = $signed({a[63], a}) - $signed({b[63], b});
      of = (sd != $signed({d[63], d}));
   endtask

   task automatic wait_done64(output int lat);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (done64) begin lat = k; break; end
      end
   endtask

   // Called at #1 after the accepting edge.
   task automatic finish64(input logic [63:0] a, input logic [63:0] b, input string tag,
                           input bit keep_start, output int lat);
      logic [63:0] d; logic bo, zf, sf, of;
      if (!keep_start) st64 = 1'b0;
      chk({tag, "_busy"}, {63'd0, busy64}, 64'd1);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      wait_done64(lat);
      chk({tag, "_lat"}, 64'(lat), 64'd64);
      model64(a, b, d, bo, zf, sf, of);
      chk({tag, "_diff"}, diff64, d);
      chk({tag, "_flags"}, {60'd0, bout64, zf64, sf64, of64}, {60'd0, bo, zf, sf, of});
   endtask

   task automatic run64(input logic [63:0] a, input logic [63:0] b, input string tag);
      int lat;
      if (done64) @(posedge clk);
      @(negedge clk);
      a64 = a; b64 = b; st64 = 1'b1;
      @(posedge clk); #1;
      finish64(a, b, tag, 1'b0, lat);
   endtask

   initial begin
      int lat, lat2, seen;
      logic [63:0] ra, rb;
      rst_n = 1'b0; st64 = 1'b0; st4 = 1'b0;
      a64 = '0; b64 = '0; a4 = '0; b4 = '0;
      #12;
      chk("reset_outs", {busy64, done64, bout64, zf64, sf64, of64, diff64[57:0]}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      run64(64'd5, 64'd3, "basic");
      run64(64'd3, 64'd5, "neg");
      chk("neg_diff_const", diff64, 64'hFFFF_FFFF_FFFF_FFFE);

      // Back-to-back at minimum interval.
      run64(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, "zero");
      chk("zero_zf", {63'd0, zf64}, 64'd1);
      a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; st64 = 1'b1;
      @(posedge clk); #1;
      chk("b2b_done_edge_busy", {63'd0, busy64}, 64'd0);
      @(posedge clk); #1;
      finish64(64'h8000_0000_0000_0000, 64'd1, "ovf", 1'b0, lat);
      chk("ovf_diff_const", diff64, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("ovf_of", {63'd0, of64}, 64'd1);

      // Start held high; operands scrambled during RUN.
      @(posedge clk);
      @(negedge clk);
      a64 = 64'd9; b64 = 64'd4; st64 = 1'b1;
      @(posedge clk); #1;
      finish64(64'd9, 64'd4, "hold1", 1'b1, lat);
      a64 = 64'd9; b64 = 64'd4;
      @(posedge clk); #1;
      chk("hold_done_ignored", {62'd0, busy64, done64}, 64'd0);
      @(posedge clk); #1;
      finish64(64'd9, 64'd4, "hold2", 1'b1, lat2);
      chk("hold_period", 64'(lat2 + 2), 64'd66);
      chk("hold_diff5", diff64, 64'd5);
      st64 = 1'b0;

      for (int i = 0; i < 12; i++) begin
         ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
         if (i % 4 == 1) rb = ra;
         if (i % 4 == 2) ra[63] = ~rb[63];
         run64(ra, rb, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset part-way through a RUN.
      run64(64'hFFFF_0000_1234_0000, 64'h0000_0000_0000_0001, "pre_rst");
      @(posedge clk);
      @(negedge clk);
      a64 = 64'd77; b64 = 64'd33; st64 = 1'b1;
      @(posedge clk); #1; st64 = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {busy64, done64, bout64, zf64, sf64, of64, diff64[57:0]}, 64'd0);
      chk("rst_mid_diff", diff64, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (done64 || busy64) seen++;
      end
      chk("rst_no_done", 64'(seen), 64'd0);
      run64(64'd10, 64'd10, "post_rst");
      chk("post_rst_zf", {63'd0, zf64}, 64'd1);

      // Exhaustive 4-bit sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            int sa, sb, sd;
            logic [3:0] d;
            if (done4) @(posedge clk);
            @(negedge clk);
            a4 = 4'(a); b4 = 4'(b); st4 = 1'b1;
            @(posedge clk); #1;
            st4 = 1'b0;
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
               @(posedge clk); #1;
               if (done4) begin lat = k; break; end
            end
            sa = (a > 7) ? a - 16 : a;
            sb = (b > 7) ? b - 16 : b;
            sd = sa - sb;
            d  = 4'(a - b);
            chk($sformatf("w4_lat_%0d_%0d", a, b), 64'(lat), 64'd4);
            chk($sformatf("w4_%0d_%0d", a, b),
                {55'd0, diff4, bout4, zf4, sf4, of4},
                {55'd0, d, (a < b), (d == 4'd0), d[3], (sd > 7 || sd < -8)});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
